// File: rtl/om_tile_mem_responder.sv
// om_tile_mem_responder
// Single-channel memory-bus responder backed by a local tile SRAM of
// 32-bit words. Serves reads in order (tag preserved) through a fixed
// LATENCY-stage pipeline and a credit-controlled response FIFO; writes are
// byte-masked and posted.
// Optional feature macro: OM_TILE_MEM_CLEAR_EN enables the tile clear FSM
// (IDLE -> DRAIN -> CLEAR -> IDLE), which zeroes the whole tile.
module om_tile_mem_responder #(
   parameter int ADDR_WIDTH     = 26,
   parameter int SIZE           = 1024,
   parameter int TAG_WIDTH      = 8,
   parameter int LATENCY        = 2,
   parameter int RSP_QUEUE_SIZE = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   input  logic                  req_rw,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [3:0]            req_byteen,
   input  logic [31:0]           req_data,
   input  logic [TAG_WIDTH-1:0]  req_tag,
   output logic                  req_ready,
   output logic                  rsp_valid,
   output logic [31:0]           rsp_data,
   output logic [TAG_WIDTH-1:0]  rsp_tag,
   input  logic                  rsp_ready,
   output logic                  addr_error,
   input  logic                  clear,
   output logic                  busy
);

   localparam int IDX_W = $clog2(SIZE);
   localparam int CNT_W = $clog2(RSP_QUEUE_SIZE + 1);
   localparam int PTR_W = (RSP_QUEUE_SIZE > 1) ? $clog2(RSP_QUEUE_SIZE) : 1;

   logic [31:0]          mem [SIZE];

   logic                 ready_q;
   logic [CNT_W-1:0]     pending_q;
   logic [CNT_W-1:0]     pending_d;
   logic                 clearing;
   logic                 clearing_d;
   logic                 clr_we;
   logic [IDX_W-1:0]     clr_idx;

   logic [IDX_W-1:0]     req_idx;
   logic                 req_oor;
   logic                 accept;
   logic                 accept_rd;
   logic                 accept_wr;

   logic [LATENCY-1:0]   pipe_valid;
   logic [31:0]          pipe_data [LATENCY];
   logic [TAG_WIDTH-1:0] pipe_tag  [LATENCY];

   logic [31:0]          fifo_data [RSP_QUEUE_SIZE];
   logic [TAG_WIDTH-1:0] fifo_tag  [RSP_QUEUE_SIZE];
   logic [PTR_W-1:0]     wr_ptr;
   logic [PTR_W-1:0]     rd_ptr;
   logic [CNT_W-1:0]     fifo_count;
   logic                 fifo_push;
   logic                 fifo_pop;

   assign req_idx   = req_addr[IDX_W-1:0];
   assign req_oor   = (req_addr >> IDX_W) != '0;
   assign req_ready = ready_q && !reset;
   assign accept    = req_valid && req_ready;
   assign accept_rd = accept && !req_rw;
   assign accept_wr = accept && req_rw && !req_oor;

   assign fifo_push = pipe_valid[LATENCY-1];
   assign fifo_pop  = rsp_valid && rsp_ready;
   assign rsp_valid = fifo_count != '0;
   assign rsp_data  = fifo_data[rd_ptr];
   assign rsp_tag   = fifo_tag[rd_ptr];
   assign busy      = clearing || (pending_q != '0);

`ifdef OM_TILE_MEM_CLEAR_EN
   typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} clr_state_t;

   clr_state_t state_q;
   clr_state_t state_d;

   // Clear FSM state register and sweep index
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         clr_idx <= '0;
      end else begin
         state_q <= state_d;
         clr_idx <= (state_q == CLEAR) ? clr_idx + 1'b1 : '0;
      end
   end

   // Clear FSM next state: wait for in-flight reads, then sweep every index
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (clear) state_d = DRAIN;
         DRAIN:   if (pipe_valid == '0) state_d = CLEAR;
         CLEAR:   if (clr_idx == {IDX_W{1'b1}}) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign clearing   = state_q != IDLE;
   assign clearing_d = state_d != IDLE;
   assign clr_we     = state_q == CLEAR;
`else
   logic unused_clear;

   assign unused_clear = clear;
   assign clearing     = 1'b0;
   assign clearing_d   = 1'b0;
   assign clr_we       = 1'b0;
   assign clr_idx      = '0;
`endif

   // Tile SRAM: clear sweep has priority, otherwise byte-masked writes
   always_ff @(posedge clk) begin
      if (clr_we) begin
         mem[clr_idx] <= '0;
      end else if (accept_wr) begin
         for (int k = 0; k < 4; k++) begin
            if (req_byteen[k]) mem[req_idx][8*k +: 8] <= req_data[8*k +: 8];
         end
      end
   end

   // Read pipeline: stage 0 captures SRAM data (zero when out of range)
   always_ff @(posedge clk) begin
      if (reset) begin
         pipe_valid <= '0;
      end else begin
         pipe_valid[0] <= accept_rd;
         for (int i = 1; i < LATENCY; i++) pipe_valid[i] <= pipe_valid[i-1];
      end
      if (accept_rd) begin
         pipe_data[0] <= req_oor ? 32'h0 : mem[req_idx];
         pipe_tag[0]  <= req_tag;
      end
      for (int i = 1; i < LATENCY; i++) begin
         pipe_data[i] <= pipe_data[i-1];
         pipe_tag[i]  <= pipe_tag[i-1];
      end
   end

   // Response FIFO: circular buffer, count unchanged on simultaneous push/pop
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (fifo_push) begin
            fifo_data[wr_ptr] <= pipe_data[LATENCY-1];
            fifo_tag[wr_ptr]  <= pipe_tag[LATENCY-1];
            wr_ptr <= (wr_ptr == PTR_W'(RSP_QUEUE_SIZE - 1)) ? '0 : wr_ptr + 1'b1;
         end
         if (fifo_pop) begin
            rd_ptr <= (rd_ptr == PTR_W'(RSP_QUEUE_SIZE - 1)) ? '0 : rd_ptr + 1'b1;
         end
         if (fifo_push && !fifo_pop)      fifo_count <= fifo_count + 1'b1;
         else if (!fifo_push && fifo_pop) fifo_count <= fifo_count - 1'b1;
      end
   end

   // Outstanding-read credit: reads in the pipeline plus queued responses
   always_comb begin
      pending_d = pending_q + CNT_W'(accept_rd) - CNT_W'(fifo_pop);
   end

   // Registered ready so a pop only frees credit on the following cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         pending_q <= '0;
         ready_q   <= 1'b1;
      end else begin
         pending_q <= pending_d;
         ready_q   <= !clearing_d && (pending_d < CNT_W'(RSP_QUEUE_SIZE));
      end
   end

   // Sticky out-of-range flag, cleared only by reset
   always_ff @(posedge clk) begin
      if (reset)                addr_error <= 1'b0;
      else if (accept && req_oor) addr_error <= 1'b1;
   end

   fifo_no_overflow: assert property (@(posedge clk) disable iff (reset)
      !(fifo_push && !fifo_pop && (fifo_count == CNT_W'(RSP_QUEUE_SIZE))));

endmodule

// File: tb/tb_om_tile_mem_responder.sv
// tb_om_tile_mem_responder
// Directed-vector bench for om_tile_mem_responder with hand-computed
// expected values. The clear sequence is exercised only when
// OM_TILE_MEM_CLEAR_EN is defined.
module tb_om_tile_mem_responder;

   localparam int AW   = 26;
   localparam int SIZE = 1024;
   localparam int TW   = 8;
   localparam int LAT  = 2;
   localparam int QS   = 4;

   logic          clk;
   logic          reset;
   logic          req_valid;
   logic          req_rw;
   logic [AW-1:0] req_addr;
   logic [3:0]    req_byteen;
   logic [31:0]   req_data;
   logic [TW-1:0] req_tag;
   logic          req_ready;
   logic          rsp_valid;
   logic [31:0]   rsp_data;
   logic [TW-1:0] rsp_tag;
   logic          rsp_ready;
   logic          addr_error;
   logic          clear;
   logic          busy;

   int            vectors;
   int            miscompares;
   logic [TW-1:0] rx_tag  [64];
   logic [31:0]   rx_data [64];
   int            rx_cnt;

   om_tile_mem_responder #(
      .ADDR_WIDTH(AW), .SIZE(SIZE), .TAG_WIDTH(TW),
      .LATENCY(LAT), .RSP_QUEUE_SIZE(QS)
   ) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr),
      .req_byteen(req_byteen), .req_data(req_data), .req_tag(req_tag),
      .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
      .rsp_ready(rsp_ready),
      .addr_error(addr_error), .clear(clear), .busy(busy)
   );

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Response monitor: records every completed handshake away from the edge
   initial rx_cnt = 0;
   always @(negedge clk) begin
      if (rsp_valid && rsp_ready && rx_cnt < 64) begin
         rx_tag[rx_cnt]  = rsp_tag;
         rx_data[rx_cnt] = rsp_data;
         rx_cnt          = rx_cnt + 1;
      end
   end

   // Count a comparison and report a miscompare
   task automatic checkOutput(input string name, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectors = vectors + 1;
      if (observed !== expected) begin
         miscompares = miscompares + 1;
         $display("[TB] FAIL %s: got %h, expected %h", name, observed, expected);
      end
   endtask

   // Present one request and hold it until accepted (returns #1 after the accept edge)
   task automatic applyStimulus(input logic rw, input logic [AW-1:0] addr,
                                input logic [3:0] be, input logic [31:0] data,
                                input logic [TW-1:0] tag);
      int n;
      req_rw     = rw;
      req_addr   = addr;
      req_byteen = be;
      req_data   = data;
      req_tag    = tag;
      req_valid  = 1'b1;
      n = 0;
      while (!req_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 50) checkOutput("req_accept_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   // Issue a read and check the returned data, tag and response latency
   task automatic readCheck(input logic [AW-1:0] addr, input logic [TW-1:0] tag,
                            input logic [31:0] exp, input string name,
                            input logic check_lat);
      int lat;
      applyStimulus(1'b0, addr, 4'h0, 32'h0, tag);
      lat = 0;
      while (!rsp_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      if (check_lat) checkOutput({name, "_latency"}, 32'(lat), 32'(LAT));
      checkOutput({name, "_data"}, rsp_data, exp);
      checkOutput({name, "_tag"}, 32'(rsp_tag), 32'(tag));
      @(posedge clk); #1;
   endtask

   initial begin
      int accepted;
      int base;
      int n;
      vectors     = 0;
      miscompares = 0;
      reset       = 1'b1;
      req_valid   = 1'b0;
      req_rw      = 1'b0;
      req_addr    = '0;
      req_byteen  = 4'h0;
      req_data    = 32'h0;
      req_tag     = '0;
      rsp_ready   = 1'b1;
      clear       = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      checkOutput("ready_in_reset", 32'(req_ready), 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;
      checkOutput("ready_after_reset", 32'(req_ready), 32'd1);
      checkOutput("rsp_valid_reset", 32'(rsp_valid), 32'd0);
      checkOutput("addr_error_reset", 32'(addr_error), 32'd0);
      checkOutput("busy_reset", 32'(busy), 32'd0);

      // Full write then read with latency check
      applyStimulus(1'b1, 26'd5, 4'hF, 32'hAABBCCDD, 8'd0);
      readCheck(26'd5, 8'd3, 32'hAABBCCDD, "wr_rd_full", 1'b1);

      // Partial byte write merges with old contents
      applyStimulus(1'b1, 26'd5, 4'b0101, 32'h11223344, 8'd0);
      readCheck(26'd5, 8'd4, 32'hAA22CC44, "byteen_0101", 1'b0);

      // byteen=0 is a no-op
      applyStimulus(1'b1, 26'd5, 4'h0, 32'h00000000, 8'd0);
      readCheck(26'd5, 8'd5, 32'hAA22CC44, "byteen_none", 1'b0);

      // Credit control: six reads against a stalled response queue
      rsp_ready = 1'b0;
      base      = rx_cnt;
      accepted  = 0;
      for (int c = 0; c < 10; c++) begin
         n          = int'(req_ready);
         req_rw     = 1'b0;
         req_addr   = 26'd5;
         req_tag    = TW'(20 + accepted);
         req_valid  = 1'b1;
         @(posedge clk); #1;
         if (n != 0) accepted++;
      end
      checkOutput("credit_accepted", 32'(accepted), 32'd4);
      checkOutput("credit_ready_low", 32'(req_ready), 32'd0);
      checkOutput("stall_tag_hold", 32'(rsp_tag), 32'd20);
      @(posedge clk); #1;
      checkOutput("stall_valid_hold", 32'(rsp_valid), 32'd1);
      checkOutput("stall_data_hold", rsp_data, 32'hAA22CC44);
      checkOutput("busy_stalled", 32'(busy), 32'd1);
      rsp_ready = 1'b1;
      for (int c = 0; c < 20 && accepted < 6; c++) begin
         n         = int'(req_ready);
         req_tag   = TW'(20 + accepted);
         req_valid = 1'b1;
         @(posedge clk); #1;
         if (n != 0) accepted++;
         if (accepted >= 6) req_valid = 1'b0;
      end
      req_valid = 1'b0;
      checkOutput("credit_all_accepted", 32'(accepted), 32'd6);
      n = 0;
      while (rx_cnt < base + 6 && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      checkOutput("credit_rsp_count", 32'(rx_cnt - base), 32'd6);
      for (int i = 0; i < 6; i++) begin
         checkOutput($sformatf("order_tag%0d", i), 32'(rx_tag[base+i]), 32'(20 + i));
         checkOutput($sformatf("order_data%0d", i), rx_data[base+i], 32'hAA22CC44);
      end

      // Out-of-range accesses
      applyStimulus(1'b1, 26'd7, 4'hF, 32'h77777777, 8'd0);
      checkOutput("addr_error_before", 32'(addr_error), 32'd0);
      readCheck(26'(SIZE + 7), 8'd9, 32'h0, "oor_read", 1'b0);
      checkOutput("addr_error_set", 32'(addr_error), 32'd1);
      applyStimulus(1'b1, 26'(SIZE + 7), 4'hF, 32'hFFFFFFFF, 8'd0);
      readCheck(26'd7, 8'd10, 32'h77777777, "oor_write_dropped", 1'b0);
      checkOutput("addr_error_sticky", 32'(addr_error), 32'd1);

      // Read the cycle right after a write to the same index
      applyStimulus(1'b1, 26'd10, 4'hF, 32'h00000001, 8'd0);
      readCheck(26'd10, 8'd11, 32'h00000001, "raw_back2back", 1'b0);

      // Reset with reads in flight discards them
      applyStimulus(1'b0, 26'd5, 4'h0, 32'h0, 8'd40);
      applyStimulus(1'b0, 26'd7, 4'h0, 32'h0, 8'd41);
      base  = rx_cnt;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      checkOutput("midreset_no_rsp", 32'(rx_cnt - base), 32'd0);
      checkOutput("midreset_busy", 32'(busy), 32'd0);
      checkOutput("midreset_addr_error", 32'(addr_error), 32'd0);
      checkOutput("midreset_ready", 32'(req_ready), 32'd1);

`ifdef OM_TILE_MEM_CLEAR_EN
      // Tile clear with two reads in flight
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, AW'(i), 4'hF, 32'h100 + 32'(i), 8'd0);
      end
      base = rx_cnt;
      applyStimulus(1'b0, 26'd0, 4'h0, 32'h0, 8'd50);
      applyStimulus(1'b0, 26'd1, 4'h0, 32'h0, 8'd51);
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      checkOutput("clear_ready_drop", 32'(req_ready), 32'd0);
      checkOutput("clear_busy", 32'(busy), 32'd1);
      n = 1;
      while (!req_ready && n < 3000) begin
         @(posedge clk); #1;
         n++;
      end
      checkOutput("clear_ready_low_len", 32'(n >= SIZE && n < 3000), 32'd1);
      checkOutput("clear_inflight_count", 32'(rx_cnt - base), 32'd2);
      checkOutput("clear_inflight0", rx_data[base], 32'h100);
      checkOutput("clear_inflight1", rx_data[base+1], 32'h101);
      for (int i = 0; i < 4; i++) begin
         readCheck(AW'(i), TW'(60 + i), 32'h0, $sformatf("cleared%0d", i), 1'b0);
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
